// File: rtl/sw_pkg.sv
// Shared types and constants for the stopwatch core.
// Optional feature macro used by the core: STOPWATCH_LAP_EN (lap/split display).
package sw_pkg;

  localparam int DIGIT_W = 4;

  typedef enum logic [1:0] {
    ST_STOP = 2'd0,
    ST_RUN  = 2'd1,
    ST_LAP  = 2'd2
  } sw_state_t;

endpackage

// File: rtl/m_updown_digit.sv
// One cascadable up/down digit with its own terminal value MAX.
// tc flags the terminal value for the current direction so the next digit
// knows this one is about to wrap.
module m_updown_digit
  import sw_pkg::*;
#(
  parameter logic [DIGIT_W-1:0] MAX = 4'd9
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               up,
  input  logic               clr,
  output logic [DIGIT_W-1:0] q,
  output logic               tc
);

  logic [DIGIT_W-1:0] q_d, q_q;

  // Next digit value: clear wins, otherwise step with wrap in either direction.
  // Counting up from a value above MAX (bad MAX change) lands on 0.
  always_comb begin
    q_d = q_q;
    if (clr) begin
      q_d = '0;
    end else if (en) begin
      if (up) q_d = (q_q >= MAX) ? '0 : q_q + 1'b1;
      else    q_d = (q_q == '0)  ? MAX : q_q - 1'b1;
    end
  end

  // Digit register, cleared asynchronously.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) q_q <= '0;
    else      q_q <= q_d;
  end

  assign q  = q_q;
  assign tc = up ? (q_q == MAX) : (q_q == '0);

endmodule

// File: rtl/m_stopwatch_core.sv
// N-digit up/down stopwatch with start/stop/lap run control.
// Optional feature: define STOPWATCH_LAP_EN to get the ST_LAP state and the
// frozen lap display; otherwise lap is ignored and disp always shows cnt.
module m_stopwatch_core
  import sw_pkg::*;
#(
  parameter int                        NDIG = 4,
  parameter logic [DIGIT_W*NDIG-1:0]   MAXV = 16'h5959
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    tick,
  input  logic                    ss,
  input  logic                    lap,
  input  logic                    clr,
  input  logic                    up,
  output logic [DIGIT_W*NDIG-1:0] cnt,
  output logic [DIGIT_W*NDIG-1:0] disp,
  output logic                    c_out,
  output logic                    running
);

  sw_state_t state_d, state_q;
  logic      count_en;
  logic      clr_cnt;
  logic [NDIG:0]                    carry;
  logic [NDIG-1:0]                  tc;
  logic [NDIG-1:0][DIGIT_W-1:0]     cnt_w;

`ifdef STOPWATCH_LAP_EN
  logic                             lap_take;
  logic [DIGIT_W*NDIG-1:0]          lap_d, lap_q;
`else
  logic                             unused_lap;
  assign unused_lap = lap;
`endif

  // Run control: clr > ss > lap; counting uses the registered state only,
  // so a tick alongside ss from STOP is dropped and one from RUN is kept.
  always_comb begin
    state_d = state_q;
    clr_cnt = 1'b0;
`ifdef STOPWATCH_LAP_EN
    lap_take = 1'b0;
`endif
    case (state_q)
      ST_STOP: begin
        if (clr)     clr_cnt = 1'b1;
        else if (ss) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (ss) state_d = ST_STOP;
`ifdef STOPWATCH_LAP_EN
        else if (lap) begin
          state_d  = ST_LAP;
          lap_take = 1'b1;
        end
`endif
      end
`ifdef STOPWATCH_LAP_EN
      ST_LAP: begin
        if (ss)       state_d = ST_STOP;
        else if (lap) state_d = ST_RUN;
      end
`endif
      default: state_d = ST_STOP;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_STOP;
    else      state_q <= state_d;
  end

  assign count_en = tick & (state_q != ST_STOP);
  assign carry[0] = count_en;

  // Digit cascade: digit i steps only when every lower digit is terminal.
  for (genvar i = 0; i < NDIG; i++) begin : g_dig
    m_updown_digit #(
      .MAX (MAXV[i*DIGIT_W +: DIGIT_W])
    ) u_dig (
      .clk (clk),
      .rst (rst),
      .en  (carry[i]),
      .up  (up),
      .clr (clr_cnt),
      .q   (cnt_w[i]),
      .tc  (tc[i])
    );
    assign carry[i+1] = carry[i] & tc[i];
  end

  assign cnt     = cnt_w;
  assign c_out   = carry[NDIG];
  assign running = (state_q != ST_STOP);

`ifdef STOPWATCH_LAP_EN
  // Lap capture takes the count held before this edge's tick.
  always_comb begin
    lap_d = lap_q;
    if (lap_take) lap_d = cnt;
  end

  // Lap register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) lap_q <= '0;
    else      lap_q <= lap_d;
  end

  assign disp = (state_q == ST_LAP) ? lap_q : cnt;
`else
  assign disp = cnt;
`endif

endmodule

// File: tb/tb_m_stopwatch_core.sv
// Bench for m_stopwatch_core (default NDIG=4, MAXV=16'h5959).
module tb_m_stopwatch_core;

`ifdef STOPWATCH_LAP_EN
  localparam bit LAP = 1'b1;
`else
  localparam bit LAP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        tick = 1'b0, ss = 1'b0, lap = 1'b0, clr = 1'b0, up = 1'b1;
  logic [15:0] cnt, disp;
  logic        c_out, running;

  m_stopwatch_core #(.NDIG(4), .MAXV(16'h5959)) dut (
    .clk(clk), .rst(rst), .tick(tick), .ss(ss), .lap(lap), .clr(clr), .up(up),
    .cnt(cnt), .disp(disp), .c_out(c_out), .running(running)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] cnt;
    logic [15:0] disp;
    logic        run;
    logic        cout;
  } exp_t;

  typedef struct {
    int          n;
    logic        tick, ss, lap, clr, up;
    logic        chk;
    logic [15:0] ecnt, edisp;
    logic        erun, ecout;
  } vec_t;

  exp_t sbq[$];
  vec_t tbl[$];
  int   checks = 0;
  int   errors = 0;
  logic last_cout;

  // reference model state
  int          md[4];
  int          mst;  // 0 stop, 1 run, 2 lap
  logic [15:0] mlap;
  logic [15:0] maxv_v = 16'h5959;

  function automatic int mx(int i);
    return int'(maxv_v[i*4 +: 4]);
  endfunction

  function automatic logic [15:0] mpack();
    logic [15:0] r;
    for (int i = 0; i < 4; i++) r[i*4 +: 4] = md[i][3:0];
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) md[i] = 0;
    mst  = 0;
    mlap = 16'h0;
  endtask

  task automatic model_step(input logic t, s, l, c, u, output exp_t e);
    bit          en, term, cy;
    logic [15:0] pre;
    en   = (mst != 0) && t;
    term = 1'b1;
    for (int i = 0; i < 4; i++)
      if (u ? (md[i] != mx(i)) : (md[i] != 0)) term = 1'b0;
    e.cout = en && term;
    pre    = mpack();
    if (mst == 0 && c) begin
      for (int i = 0; i < 4; i++) md[i] = 0;
    end else if (en) begin
      cy = 1'b1;
      for (int i = 0; i < 4; i++) begin
        if (cy) begin
          if (u) begin
            if (md[i] >= mx(i)) md[i] = 0;
            else begin md[i] = md[i] + 1; cy = 1'b0; end
          end else begin
            if (md[i] == 0) md[i] = mx(i);
            else begin md[i] = md[i] - 1; cy = 1'b0; end
          end
        end
      end
    end
    case (mst)
      0: if (!c && s) mst = 1;
      1: if (s) mst = 0;
         else if (LAP && l) begin mlap = pre; mst = 2; end
      default: if (s) mst = 0; else if (l) mst = 1;
    endcase
    e.cnt  = mpack();
    e.run  = (mst != 0);
    e.disp = (mst == 2) ? mlap : e.cnt;
  endtask

  task automatic chk16(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  // One clock of stimulus: drive at negedge, push model result, sample the
  // combinational c_out before the edge and registered outputs after it.
  task automatic step(input logic t, s, l, c, u);
    exp_t e, g;
    @(negedge clk);
    tick = t; ss = s; lap = l; clr = c; up = u;
    model_step(t, s, l, c, u, e);
    sbq.push_back(e);
    #1 last_cout = c_out;
    @(posedge clk);
    #1;
    checks++;
    if (sbq.size() == 0) begin
      errors++;
      $display("FAIL sb_empty: got 0 entries expected 1");
    end else begin
      checks--;
      g = sbq.pop_front();
      chk16("sb_cnt", cnt, g.cnt);
      chk16("sb_disp", disp, g.disp);
      chk1("sb_running", running, g.run);
      chk1("sb_c_out", last_cout, g.cout);
    end
  endtask

  function automatic vec_t mk(int n, logic t, s, l, c, u, logic k,
                              logic [15:0] ec, logic [15:0] ed, logic er, logic eco);
    vec_t v;
    v.n = n; v.tick = t; v.ss = s; v.lap = l; v.clr = c; v.up = u;
    v.chk = k; v.ecnt = ec; v.edisp = ed; v.erun = er; v.ecout = eco;
    return v;
  endfunction

  initial begin
    //             n    tk ss lp cl up  chk cnt       disp                       run cout
    tbl.push_back(mk(1,    1, 1, 0, 0, 1, 1, 16'h0000, 16'h0000,                  1, 0));
    tbl.push_back(mk(10,   1, 0, 0, 0, 1, 1, 16'h0010, 16'h0010,                  1, 0));
    tbl.push_back(mk(49,   1, 0, 0, 0, 1, 1, 16'h0059, 16'h0059,                  1, 0));
    tbl.push_back(mk(1,    1, 0, 0, 0, 1, 1, 16'h0100, 16'h0100,                  1, 0));
    tbl.push_back(mk(3539, 1, 0, 0, 0, 1, 1, 16'h5959, 16'h5959,                  1, 0));
    tbl.push_back(mk(1,    1, 0, 0, 0, 1, 1, 16'h0000, 16'h0000,                  1, 1));
    tbl.push_back(mk(3,    0, 0, 0, 0, 1, 1, 16'h0000, 16'h0000,                  1, 0));
    tbl.push_back(mk(12,   1, 0, 0, 0, 1, 1, 16'h0012, 16'h0012,                  1, 0));
    tbl.push_back(mk(1,    0, 0, 1, 0, 1, 1, 16'h0012, 16'h0012,                  1, 0));
    tbl.push_back(mk(5,    1, 0, 0, 0, 1, 1, 16'h0017, LAP ? 16'h0012 : 16'h0017, 1, 0));
    tbl.push_back(mk(1,    0, 0, 1, 0, 1, 1, 16'h0017, 16'h0017,                  1, 0));
    tbl.push_back(mk(1,    1, 0, 1, 0, 1, 1, 16'h0018, LAP ? 16'h0017 : 16'h0018, 1, 0));
    tbl.push_back(mk(1,    0, 0, 1, 0, 1, 1, 16'h0018, 16'h0018,                  1, 0));
    tbl.push_back(mk(1,    0, 0, 0, 1, 1, 1, 16'h0018, 16'h0018,                  1, 0));
    tbl.push_back(mk(1,    1, 0, 0, 0, 0, 1, 16'h0017, 16'h0017,                  1, 0));
    tbl.push_back(mk(1,    1, 0, 0, 0, 1, 1, 16'h0018, 16'h0018,                  1, 0));
    tbl.push_back(mk(1,    1, 1, 0, 0, 1, 1, 16'h0019, 16'h0019,                  0, 0));
    tbl.push_back(mk(4,    1, 0, 0, 0, 1, 1, 16'h0019, 16'h0019,                  0, 0));
    tbl.push_back(mk(1,    0, 0, 1, 0, 1, 1, 16'h0019, 16'h0019,                  0, 0));
    tbl.push_back(mk(1,    0, 1, 0, 0, 1, 1, 16'h0019, 16'h0019,                  1, 0));
    tbl.push_back(mk(1,    0, 1, 1, 0, 1, 1, 16'h0019, 16'h0019,                  0, 0));
    tbl.push_back(mk(1,    0, 0, 0, 1, 1, 1, 16'h0000, 16'h0000,                  0, 0));
    tbl.push_back(mk(1,    0, 1, 0, 0, 1, 1, 16'h0000, 16'h0000,                  1, 0));
    tbl.push_back(mk(1,    1, 1, 0, 1, 1, 1, 16'h0001, 16'h0001,                  0, 0));
    tbl.push_back(mk(1,    0, 1, 0, 1, 1, 1, 16'h0000, 16'h0000,                  0, 0));
    tbl.push_back(mk(1,    0, 1, 0, 0, 0, 1, 16'h0000, 16'h0000,                  1, 0));
    tbl.push_back(mk(1,    1, 0, 0, 0, 0, 1, 16'h5959, 16'h5959,                  1, 1));
    tbl.push_back(mk(1,    1, 0, 0, 0, 0, 1, 16'h5958, 16'h5958,                  1, 0));
    tbl.push_back(mk(1,    0, 0, 1, 0, 0, 1, 16'h5958, 16'h5958,                  1, 0));
    tbl.push_back(mk(1,    1, 0, 0, 0, 0, 1, 16'h5957, LAP ? 16'h5958 : 16'h5957, 1, 0));
    tbl.push_back(mk(1,    0, 1, 1, 0, 0, 1, 16'h5957, 16'h5957,                  0, 0));
    tbl.push_back(mk(1,    0, 0, 0, 1, 1, 1, 16'h0000, 16'h0000,                  0, 0));
    tbl.push_back(mk(1,    0, 1, 0, 0, 1, 1, 16'h0000, 16'h0000,                  1, 0));
    tbl.push_back(mk(225,  1, 0, 0, 0, 1, 1, 16'h0345, 16'h0345,                  1, 0));

    // reset state
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk16("rst_cnt", cnt, 16'h0000);
    chk16("rst_disp", disp, 16'h0000);
    chk1("rst_running", running, 1'b0);
    chk1("rst_c_out", c_out, 1'b0);
    @(negedge clk);
    rst = 1'b1;

    // table-driven vectors
    foreach (tbl[k]) begin
      for (int r = 0; r < tbl[k].n; r++)
        step(tbl[k].tick, tbl[k].ss, tbl[k].lap, tbl[k].clr, tbl[k].up);
      if (tbl[k].chk) begin
        chk16($sformatf("v%0d_cnt", k), cnt, tbl[k].ecnt);
        chk16($sformatf("v%0d_disp", k), disp, tbl[k].edisp);
        chk1($sformatf("v%0d_running", k), running, tbl[k].erun);
        chk1($sformatf("v%0d_c_out", k), last_cout, tbl[k].ecout);
      end
    end

    // async reset mid-run at 0345, asserted between clock edges
    tick = 1'b1; ss = 1'b0; lap = 1'b0; clr = 1'b0; up = 1'b1;
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk16("arst_cnt", cnt, 16'h0000);
    chk16("arst_disp", disp, 16'h0000);
    chk1("arst_running", running, 1'b0);
    chk1("arst_c_out", c_out, 1'b0);
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b1;

    // ticks without ss after release must not count
    repeat (5) step(1, 0, 0, 0, 1);
    chk16("post_rst_cnt", cnt, 16'h0000);
    chk1("post_rst_running", running, 1'b0);

    // ss restarts counting
    step(0, 1, 0, 0, 1);
    step(1, 0, 0, 0, 1);
    step(1, 0, 0, 0, 1);
    chk16("resume_cnt", cnt, 16'h0002);
    chk1("resume_running", running, 1'b1);

    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover: got %0d entries expected 0", sbq.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
